window_packer: RTL and testbench



---
 rtl/window_packer.sv | 216 +++++++++++++++++++++
 tb/tb_window_packer.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_packer.sv
`default_nettype none
// ============================================================================
//  Module   : window_packer
//  Purpose  : Transmit side of the denoise window interface. Collects a raster
//             pixel stream (one BIT_WIDTH pixel per accepted beat) into a
//             WIN_H x WIN_W row-major window and presents it as one wide word
//             with a valid/ready handshake.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1             clock, rising edge
//    rst_n      in   1             synchronous active-low reset
//    in_valid   in   1             pixel beat valid
//    in_ready   out  1             packer can accept a beat
//    in_sof     in   1             start of frame, restarts the window fill
//    in_pixel   in   BIT_WIDTH     pixel value
//    win_valid  out  1             complete window presented
//    win_ready  in   1             downstream consumes the window
//    win_data   out  BIT_WIDTH*N   window, pixel k at [BIT_WIDTH*k +: BIT_WIDTH]
//    win_count  out  CNT_W         windows consumed since reset (wrapping)
// ----------------------------------------------------------------------------
//  Build option
//    WINDOW_PACKER_PINGPONG_EN : two window buffers, filling continues into
//                                the spare buffer while the other is held.
//                                Undefined: single buffer, input stalls
//                                while a window is held.
// ============================================================================
module window_packer #(
  parameter int BIT_WIDTH = 8,
  parameter int WIN_W     = 10,
  parameter int WIN_H     = 7,
  parameter int CNT_W     = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic                               in_sof,
  input  logic [BIT_WIDTH-1:0]               in_pixel,
  output logic                               win_valid,
  input  logic                               win_ready,
  output logic [BIT_WIDTH*WIN_W*WIN_H-1:0]   win_data,
  output logic [CNT_W-1:0]                   win_count
);

  localparam int                 c_npix     = WIN_W * WIN_H;
  localparam int                 c_idx_w    = (c_npix > 1) ? $clog2(c_npix) : 1;
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(c_npix - 1);

  // HOLD means a complete window is being presented; win_valid is this state.
  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_idx_w-1:0] r_idx;
  logic [c_idx_w-1:0] w_idx_nxt;
  logic [c_idx_w-1:0] w_slot;
  logic               r_in_ready;
  logic               w_in_ready_nxt;
  logic [CNT_W-1:0]   r_win_count;
  logic [CNT_W-1:0]   w_win_count_nxt;
  logic               w_accept;
  logic               w_fill_done;
  logic               w_handshake;

  assign w_accept    = in_valid && r_in_ready;
  assign w_handshake = (r_state == HOLD) && win_ready;

  // A start-of-frame beat always lands in slot 0, discarding the partial fill.
  assign w_slot      = in_sof ? '0 : r_idx;
  assign w_fill_done = w_accept && (in_sof ? (c_npix == 1) : (r_idx == c_last_idx));

  // --------------------------------------------------------------------------
  // Fill index: shared by both buffer organisations
  // --------------------------------------------------------------------------
  always_comb begin
    w_idx_nxt = r_idx;
    if (w_accept) begin
      if (w_fill_done) begin
        w_idx_nxt = '0;
      end else if (in_sof) begin
        w_idx_nxt = c_idx_w'(1);
      end else begin
        w_idx_nxt = r_idx + 1'b1;
      end
    end
  end

`ifdef WINDOW_PACKER_PINGPONG_EN
  // --------------------------------------------------------------------------
  // Ping-pong organisation. Buffers are filled and presented in the same
  // alternating order, so two select bits plus a full flag per buffer are
  // enough to track ownership.
  // --------------------------------------------------------------------------
  logic [BIT_WIDTH*c_npix-1:0] r_buf [2];
  logic [1:0]                  r_full;
  logic [1:0]                  w_full_nxt;
  logic                        r_fill_sel;
  logic                        w_fill_sel_nxt;
  logic                        r_hold_sel;
  logic                        w_hold_sel_nxt;
  logic                        w_win_valid_nxt;

  always_comb begin
    w_full_nxt      = r_full;
    w_fill_sel_nxt  = r_fill_sel;
    w_hold_sel_nxt  = r_hold_sel;
    w_win_count_nxt = r_win_count;

    // The filling buffer is never the one being presented while full, so a
    // completing fill and a handshake always touch different buffers.
    if (w_fill_done) begin
      w_full_nxt[r_fill_sel] = 1'b1;
      w_fill_sel_nxt         = ~r_fill_sel;
    end
    if (w_handshake) begin
      w_full_nxt[r_hold_sel] = 1'b0;
      w_hold_sel_nxt         = ~r_hold_sel;
      w_win_count_nxt        = r_win_count + 1'b1;
    end

    // A fill completing on the handshake cycle is already counted full here,
    // so the window stream stays valid without a bubble.
    w_win_valid_nxt = w_full_nxt[w_hold_sel_nxt];
    w_in_ready_nxt  = ~&w_full_nxt;
    w_state_nxt     = w_win_valid_nxt ? HOLD : FILL;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_buf[0]   <= '0;
      r_buf[1]   <= '0;
      r_full     <= '0;
      r_fill_sel <= 1'b0;
      r_hold_sel <= 1'b0;
    end else begin
      if (w_accept) begin
        r_buf[r_fill_sel][w_slot*BIT_WIDTH +: BIT_WIDTH] <= in_pixel;
      end
      r_full     <= w_full_nxt;
      r_fill_sel <= w_fill_sel_nxt;
      r_hold_sel <= w_hold_sel_nxt;
    end
  end

  assign win_data = r_buf[r_hold_sel];

`else
  // --------------------------------------------------------------------------
  // Single buffer organisation. Input is stalled for the whole HOLD period,
  // which is what keeps win_data stable while it is presented.
  // --------------------------------------------------------------------------
  logic [BIT_WIDTH*c_npix-1:0] r_buf;

  always_comb begin
    w_state_nxt     = r_state;
    w_in_ready_nxt  = r_in_ready;
    w_win_count_nxt = r_win_count;

    case (r_state)
      FILL: begin
        if (w_fill_done) begin
          w_state_nxt    = HOLD;
          w_in_ready_nxt = 1'b0;
        end
      end
      HOLD: begin
        if (w_handshake) begin
          w_state_nxt     = FILL;
          w_in_ready_nxt  = 1'b1;
          w_win_count_nxt = r_win_count + 1'b1;
        end
      end
      default: begin
        w_state_nxt = FILL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_buf <= '0;
    end else if (w_accept) begin
      r_buf[w_slot*BIT_WIDTH +: BIT_WIDTH] <= in_pixel;
    end
  end

  assign win_data = r_buf;
`endif

  // --------------------------------------------------------------------------
  // State and control registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= FILL;
      r_idx       <= '0;
      r_in_ready  <= 1'b1;
      r_win_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_win_count <= w_win_count_nxt;
    end
  end

  assign win_valid = (r_state == HOLD);
  assign in_ready  = r_in_ready;
  assign win_count = r_win_count;

endmodule
`default_nettype wire

// File: tb/tb_window_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_window_packer
//  Purpose  : Directed, self-checking bench for window_packer. Each scenario
//             task drives stimulus and compares against hand-computed values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_window_packer;

  localparam int BW = 8;
  localparam int WW = 10;
  localparam int WH = 7;
  localparam int NP = WW * WH;
  localparam int CW = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic              in_sof;
  logic [BW-1:0]     in_pixel;
  logic              win_valid;
  logic              win_ready;
  logic [BW*NP-1:0]  win_data;
  logic [CW-1:0]     win_count;

  int                checks    = 0;
  int                errors    = 0;
  int                exp_count = 0;
  bit                abort     = 1'b0;
  logic [BW*NP-1:0]  exp_win;

  window_packer #(
    .BIT_WIDTH (BW),
    .WIN_W     (WW),
    .WIN_H     (WH),
    .CNT_W     (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sof    (in_sof),
    .in_pixel  (in_pixel),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_data  (win_data),
    .win_count (win_count)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one clock; inputs are driven and outputs sampled 1 time unit
  // after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pix_val(input int w, input int k);
    return 8'((w * 13 + k * 5 + 1) & 255);
  endfunction

  // Present one beat and hold it until accepted (bounded).
  task automatic send_beat(input logic [7:0] pix, input logic sof);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_pixel = pix;
    in_sof   = sof;
    while (!in_ready && n < 1000) begin
      step();
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      abort = 1'b1;
      $display("FAIL send_beat_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, n);
    end
    step();
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    in_pixel  = '0;
    win_ready = 1'b0;
    step();
    step();
    checks++; if (win_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", win_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b expected 1", in_ready); end
    checks++; if (win_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", win_count); end
    checks++; if (win_data !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", win_data); end
    rst_n = 1'b1;
    exp_count = 0;
  endtask

  task automatic test_fill_hold();
    for (int k = 0; k < NP; k++) begin
      exp_win[k*BW +: BW] = 8'(k);
      send_beat(8'(k), 1'b0);
      if (k == NP - 2) begin
        checks++; if (win_valid !== 1'b0) begin errors++; $display("FAIL fill_valid_early: got %0b expected 0", win_valid); end
      end
    end
    checks++; if (win_valid !== 1'b1) begin errors++; $display("FAIL fill_valid: got %0b expected 1", win_valid); end
    checks++; if (win_data[7:0] !== 8'h00) begin errors++; $display("FAIL fill_pix0: got %h expected 00", win_data[7:0]); end
    checks++; if (win_data[559:552] !== 8'h45) begin errors++; $display("FAIL fill_pix69: got %h expected 45", win_data[559:552]); end
    checks++; if (win_data !== exp_win) begin errors++; $display("FAIL fill_data: got %h expected %h", win_data, exp_win); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_ready: got %0b expected 0", in_ready); end
    // Offered beats (even with sof) must not be taken while the window is held.
    in_valid = 1'b1;
    in_sof   = 1'b1;
    in_pixel = 8'h5A;
    for (int c = 0; c < 20; c++) begin
      step();
      checks++;
      if ({win_valid, in_ready, win_data} !== {1'b1, 1'b0, exp_win}) begin
        errors++;
        $display("FAIL hold_stable cycle %0d: valid=%0b ready=%0b data=%h expected valid=1 ready=0 data=%h",
                 c, win_valid, in_ready, win_data, exp_win);
      end
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic test_handoff();
    win_ready = 1'b1;
    step();
    win_ready = 1'b0;
    exp_count++;
    checks++; if (win_valid !== 1'b0) begin errors++; $display("FAIL handoff_valid: got %0b expected 0", win_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL handoff_ready: got %0b expected 1", in_ready); end
    checks++; if (win_count !== 16'(exp_count)) begin errors++; $display("FAIL handoff_count: got %0d expected %0d", win_count, exp_count); end
    // win_ready without a presented window must not count anything.
    win_ready = 1'b1;
    step();
    step();
    win_ready = 1'b0;
    checks++; if (win_count !== 16'(exp_count)) begin errors++; $display("FAIL idle_ready_count: got %0d expected %0d", win_count, exp_count); end
    for (int k = 0; k < NP; k++) begin
      exp_win[k*BW +: BW] = 8'(255 - k);
      send_beat(8'(255 - k), 1'b0);
    end
    checks++; if (win_valid !== 1'b1) begin errors++; $display("FAIL second_valid: got %0b expected 1", win_valid); end
    checks++; if (win_data[7:0] !== 8'hFF) begin errors++; $display("FAIL second_pix0: got %h expected ff", win_data[7:0]); end
    checks++; if (win_data !== exp_win) begin errors++; $display("FAIL second_data: got %h expected %h", win_data, exp_win); end
    win_ready = 1'b1;
    step();
    win_ready = 1'b0;
    exp_count++;
    checks++; if (win_count !== 16'(exp_count)) begin errors++; $display("FAIL second_count: got %0d expected %0d", win_count, exp_count); end
  endtask

  task automatic test_sof();
    for (int i = 0; i < 30; i++) begin
      send_beat(8'(8'h10 + i), 1'b0);
    end
    exp_win[7:0] = 8'hAA;
    send_beat(8'hAA, 1'b1);
    for (int j = 1; j < NP; j++) begin
      exp_win[j*BW +: BW] = 8'(8'h40 + j);
      send_beat(8'(8'h40 + j), 1'b0);
      if (j == 39) begin
        checks++; if (win_valid !== 1'b0) begin errors++; $display("FAIL sof_no_window_at_70: got %0b expected 0", win_valid); end
      end
    end
    checks++; if (win_valid !== 1'b1) begin errors++; $display("FAIL sof_valid: got %0b expected 1", win_valid); end
    checks++; if (win_data[7:0] !== 8'hAA) begin errors++; $display("FAIL sof_slot0: got %h expected aa", win_data[7:0]); end
    checks++; if (win_data !== exp_win) begin errors++; $display("FAIL sof_data: got %h expected %h", win_data, exp_win); end
    win_ready = 1'b1;
    step();
    win_ready = 1'b0;
    exp_count++;
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 40; k++) begin
      send_beat(8'(k + 3), 1'b0);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_count = 0;
    checks++;
    if ({win_valid, in_ready, win_count} !== {1'b1 ^ 1'b1, 1'b1, 16'd0} || win_data !== '0) begin
      errors++;
      $display("FAIL reset_mid_fill: valid=%0b ready=%0b count=%0d data=%h expected 0 1 0 0", win_valid, in_ready, win_count, win_data);
    end
    for (int k = 0; k < NP; k++) begin
      exp_win[k*BW +: BW] = 8'(k * 3);
      send_beat(8'(k * 3), 1'b0);
      if (k == NP - 2) begin
        checks++; if (win_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_early: got %0b expected 0", win_valid); end
      end
    end
    checks++; if (win_valid !== 1'b1 || win_data !== exp_win) begin errors++; $display("FAIL reset_mid_window: valid=%0b data=%h expected 1 %h", win_valid, win_data, exp_win); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if (win_valid !== 1'b0 || in_ready !== 1'b1 || win_count !== 16'd0 || win_data !== '0) begin
      errors++;
      $display("FAIL reset_in_hold: valid=%0b ready=%0b count=%0d data=%h expected 0 1 0 0", win_valid, in_ready, win_count, win_data);
    end
    for (int k = 0; k < NP; k++) begin
      exp_win[k*BW +: BW] = 8'(k + 100);
      send_beat(8'(k + 100), 1'b0);
    end
    checks++; if (win_valid !== 1'b1 || win_data !== exp_win) begin errors++; $display("FAIL reset_fresh_window: valid=%0b data=%h expected 1 %h", win_valid, win_data, exp_win); end
    win_ready = 1'b1;
    step();
    win_ready = 1'b0;
    exp_count++;
    checks++; if (win_count !== 16'(exp_count)) begin errors++; $display("FAIL reset_fresh_count: got %0d expected %0d", win_count, exp_count); end
  endtask

  task automatic test_random();
    fork
      begin : producer
        for (int g = 0; g < 100 * NP && !abort; g++) begin
          while ($urandom_range(0, 1) == 1) step();
          send_beat(pix_val(g / NP, g % NP), 1'b0);
        end
      end
      begin : consumer
        logic [BW*NP-1:0] e;
        int cyc;
        int w;
        cyc = 0;
        w   = 0;
        while (w < 100 && cyc < 60000 && !abort) begin
          win_ready = 1'($urandom_range(0, 1));
          if (win_valid && win_ready) begin
            for (int k = 0; k < NP; k++) e[k*BW +: BW] = pix_val(w, k);
            checks++;
            if (win_data !== e) begin
              errors++;
              $display("FAIL random_window %0d: got %h expected %h", w, win_data, e);
            end
            w++;
          end
          step();
          cyc++;
        end
        win_ready = 1'b0;
        if (w < 100) begin
          checks++;
          errors++;
          abort = 1'b1;
          $display("FAIL random_timeout: windows received %0d, required 100", w);
        end
      end
    join
    exp_count += 100;
    step();
    checks++; if (win_count !== 16'(exp_count)) begin errors++; $display("FAIL random_count: got %0d expected %0d", win_count, exp_count); end
    checks++; if (win_valid !== 1'b0) begin errors++; $display("FAIL random_extra_window: got %0b expected 0", win_valid); end
  endtask

`ifdef WINDOW_PACKER_PINGPONG_EN
  task automatic test_pingpong();
    int drops;
    int bad;
    int pulses;
    int acc;
    drops  = 0;
    bad    = 0;
    pulses = 0;
    acc    = 0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    win_ready = 1'b1;
    in_valid  = 1'b1;
    in_sof    = 1'b0;
    for (int b = 0; b < 3 * NP; b++) begin
      in_pixel = 8'(b);
      if (!in_ready) drops++;
      step();
      if (win_valid) pulses++;
      if (win_valid !== ((b % NP) == NP - 1)) bad++;
      if (b == NP - 1) begin
        checks++; if (win_data[559:552] !== 8'h45) begin errors++; $display("FAIL pp_first_pix69: got %h expected 45", win_data[559:552]); end
      end
      if (b == 3 * NP - 1) begin
        for (int k = 0; k < NP; k++) exp_win[k*BW +: BW] = 8'(2 * NP + k);
        checks++; if (win_data !== exp_win) begin errors++; $display("FAIL pp_third_data: got %h expected %h", win_data, exp_win); end
      end
    end
    in_valid = 1'b0;
    step();
    win_ready = 1'b0;
    checks++; if (drops !== 0) begin errors++; $display("FAIL pp_ready_drops: got %0d expected 0", drops); end
    checks++; if (bad !== 0 || pulses !== 3) begin errors++; $display("FAIL pp_pulses: misplaced=%0d pulses=%0d expected 0 and 3", bad, pulses); end
    checks++; if (win_count !== 16'd3 || win_valid !== 1'b0) begin errors++; $display("FAIL pp_count: count=%0d valid=%0b expected 3 0", win_count, win_valid); end
    in_valid = 1'b1;
    for (int c = 0; c < 150; c++) begin
      in_pixel = 8'(c);
      if (in_ready) acc++;
      step();
    end
    in_valid = 1'b0;
    checks++; if (acc !== 2 * NP) begin errors++; $display("FAIL pp_stall_accepts: got %0d expected %0d", acc, 2 * NP); end
    checks++; if (in_ready !== 1'b0 || win_valid !== 1'b1) begin errors++; $display("FAIL pp_stall_state: ready=%0b valid=%0b expected 0 1", in_ready, win_valid); end
    win_ready = 1'b1;
    step();
    win_ready = 1'b0;
    checks++;
    if (win_valid !== 1'b1 || in_ready !== 1'b1 || win_data[7:0] !== 8'h46) begin
      errors++;
      $display("FAIL pp_switch: valid=%0b ready=%0b pix0=%h expected 1 1 46", win_valid, in_ready, win_data[7:0]);
    end
    win_ready = 1'b1;
    step();
    win_ready = 1'b0;
    checks++; if (win_valid !== 1'b0 || win_count !== 16'd5) begin errors++; $display("FAIL pp_drain: valid=%0b count=%0d expected 0 5", win_valid, win_count); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef WINDOW_PACKER_PINGPONG_EN
    test_random();
    test_pingpong();
`else
    test_fill_hold();
    test_handoff();
    test_sof();
    test_reset_mid();
    test_random();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
